// File: rtl/uart_tx_ctrl_if.sv
// Byte-stream handshake between the UART register block and the transmitter.
interface uart_tx_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: programmable divisor, 5-8 data bits, parity, 1/2 stop bits.
// Define UART_TX_FIFO_EN to add a FIFO_DEPTH-entry TX FIFO with back-to-back frames.
module uart_tx_ctrl #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic [1:0]        cfg_data_bits_i,
    input  logic [1:0]        cfg_parity_i,
    input  logic              cfg_stop_bits_i,
    uart_tx_ctrl_if.slave     tx_if,
    output logic              tx_o,
    output logic              busy_o,
    output logic [LVL_W-1:0]  fifo_level_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n, div_q;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shifter, shifter_n;
    logic [1:0]       nbits_q;
    logic             par_en_q, par_bit_q, stop2_q;
    logic             bit_done, frame_end, load, avail;
    logic [7:0]       src_byte, data_mask;
    logic             par_bit_in, tx_n, busy_n;

    assign bit_done   = (cnt == div_q);
    assign data_mask  = 8'hFF >> (2'd3 - cfg_data_bits_i);
    assign par_bit_in = (^(src_byte & data_mask)) ^ (cfg_parity_i == 2'b10);

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level, level_n;
    logic             push;

    assign tx_if.tx_ready = cfg_en_i && (level != LVL_W'(FIFO_DEPTH));
    assign push           = tx_if.tx_valid && tx_if.tx_ready;
    assign avail          = (level != '0);
    assign src_byte       = mem[rd_ptr];
    assign fifo_level_o   = level;
    assign level_n        = cfg_en_i ? (level + LVL_W'(push) - LVL_W'(load)) : '0;
    assign busy_n         = (state_n != S_IDLE) || (level_n != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_if.tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst || !cfg_en_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            level <= level_n;
        end
    end
`else
    assign tx_if.tx_ready = cfg_en_i && (state == S_IDLE);
    assign avail          = tx_if.tx_valid && tx_if.tx_ready;
    assign src_byte       = tx_if.tx_data;
    assign fifo_level_o   = '0;
    assign busy_n         = (state_n != S_IDLE);
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = bit_done ? '0 : cnt + 1'b1;
        bit_idx_n = bit_idx;
        shifter_n = shifter;
        load      = 1'b0;
        frame_end = 1'b0;
        tx_n      = 1'b1;

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (avail) begin
                    load    = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: if (bit_done) begin
                state_n   = S_DATA;
                bit_idx_n = '0;
            end
            S_DATA: if (bit_done) begin
                shifter_n = shifter >> 1;
                if (bit_idx == 3'd4 + {1'b0, nbits_q})
                    state_n = par_en_q ? S_PARITY : S_STOP1;
                else
                    bit_idx_n = bit_idx + 1'b1;
            end
            S_PARITY: if (bit_done) state_n = S_STOP1;
            S_STOP1:  if (bit_done) begin
                if (stop2_q) state_n = S_STOP2;
                else         frame_end = 1'b1;
            end
            S_STOP2:  if (bit_done) frame_end = 1'b1;
            default:  state_n = S_IDLE;
        endcase

        // Without the FIFO avail is never true here, so frames always end in IDLE.
        if (frame_end) begin
            if (avail) begin
                load    = 1'b1;
                state_n = S_START;
            end else begin
                state_n = S_IDLE;
            end
        end

        if (!cfg_en_i) begin
            state_n = S_IDLE;
            load    = 1'b0;
        end

        if (load)              shifter_n = src_byte;
        if (state_n != state)  cnt_n     = '0;

        // Line is registered from the next-state view so it changes with the state.
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shifter_n[0];
            S_PARITY: tx_n = par_bit_q;
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shifter   <= '0;
            div_q     <= '0;
            nbits_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_o      <= 1'b1;
            busy_o    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shifter <= shifter_n;
            tx_o    <= tx_n;
            busy_o  <= busy_n;
            if (load) begin
                div_q     <= cfg_div_i;
                nbits_q   <= cfg_data_bits_i;
                par_en_q  <= cfg_parity_i[0] ^ cfg_parity_i[1];
                par_bit_q <= par_bit_in;
                stop2_q   <= cfg_stop_bits_i;
            end
        end
    end

endmodule
